interboard_link_tx: RTL

INTERBOARD_LINK_TX -- requirements
Module: interboard_link_tx

---
 rtl/interboard_link_tx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/interboard_link_tx.sv
// Credit-based transmitter: round-robin multiplexes NCH channels onto one link word per cycle.
// Optional feature macro INTERBOARD_PARITY_EN adds registered even parity on link_par.
module interboard_link_tx #(
  parameter  int DATA_W  = 11,
  parameter  int NCH     = 2,
  parameter  int CREDITS = 8,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int CR_W    = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  link_en,
  input  logic [NCH-1:0]        ch_valid,
  input  logic [NCH*DATA_W-1:0] ch_data,
  output logic [NCH-1:0]        ch_ready,
  output logic                  link_valid,
  output logic [DATA_W-1:0]     link_data,
  output logic [CH_W-1:0]       link_ch,
  output logic                  link_par,
  input  logic                  credit_ret,
  output logic [CR_W-1:0]       credit_cnt,
  output logic                  link_idle,
  output logic                  err_credit_ovf
);

  localparam int CW1 = CH_W + 1;

  typedef enum logic [1:0] {ST_DOWN, ST_ACTIVE, ST_DRAIN} state_t;

  state_t              state;
  logic [CH_W-1:0]     rr_ptr;
  logic [CH_W-1:0]     gnt_idx;
  logic [CH_W-1:0]     rr_next;
  logic [CW1-1:0]      cand;
  logic                gnt_found;
  logic                accept;
  logic [DATA_W-1:0]   gnt_data;
  logic                vld_p0;
  logic [DATA_W-1:0]   data_p0;
  logic [CH_W-1:0]     ch_p0;

  // Counter saturates at CREDITS; an accept and a return in the same cycle cancel.
  function automatic logic [CR_W-1:0] credit_next(input logic [CR_W-1:0] cnt,
                                                  input logic take, input logic give);
    logic [CR_W-1:0] nxt;
    nxt = cnt;
    if (take && !give)
      nxt = cnt - CR_W'(1);
    else if (give && !take && (cnt != CR_W'(CREDITS)))
      nxt = cnt + CR_W'(1);
    return nxt;
  endfunction

  function automatic logic credit_ovf(input logic [CR_W-1:0] cnt,
                                      input logic take, input logic give);
    return give && !take && (cnt == CR_W'(CREDITS));
  endfunction

  // Round-robin search from rr_ptr; cand carries one spare bit so the wrap never overflows.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr;
    cand      = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = {1'b0, rr_ptr} + CW1'(k);
      if (cand >= CW1'(NCH))
        cand = cand - CW1'(NCH);
      if (!gnt_found && ch_valid[cand[CH_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[CH_W-1:0];
      end
    end
  end

  assign accept   = (state == ST_ACTIVE) && (credit_cnt != '0) && gnt_found;
  assign ch_ready = accept ? (NCH'(1) << gnt_idx) : '0;
  assign gnt_data = ch_data[int'(gnt_idx) * DATA_W +: DATA_W];
  assign rr_next  = (gnt_idx == CH_W'(NCH - 1)) ? '0 : gnt_idx + CH_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_DOWN;
      link_idle      <= 1'b1;
      rr_ptr         <= '0;
      credit_cnt     <= CR_W'(CREDITS);
      err_credit_ovf <= 1'b0;
    end else begin
      credit_cnt <= credit_next(credit_cnt, accept, credit_ret);
      if (credit_ovf(credit_cnt, accept, credit_ret))
        err_credit_ovf <= 1'b1;
      if (accept)
        rr_ptr <= rr_next;
      case (state)
        ST_DOWN: begin
          if (link_en) begin
            state     <= ST_ACTIVE;
            link_idle <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (!link_en)
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (link_en) begin
            state <= ST_ACTIVE;
          end else if (credit_cnt == CR_W'(CREDITS)) begin
            state     <= ST_DOWN;
            link_idle <= 1'b1;
          end
        end
        default: begin
          state     <= ST_DOWN;
          link_idle <= 1'b1;
        end
      endcase
    end
  end

  // Stage p0: accepted word registered for emission; reset drops any pending word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      ch_p0   <= '0;
    end else begin
      vld_p0 <= accept;
      if (accept) begin
        data_p0 <= gnt_data;
        ch_p0   <= gnt_idx;
      end
    end
  end

  assign link_valid = vld_p0;
  assign link_data  = data_p0;
  assign link_ch    = ch_p0;

`ifdef INTERBOARD_PARITY_EN
  logic par_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      par_p0 <= 1'b0;
    else if (accept)
      par_p0 <= ^{gnt_idx, gnt_data};
  end

  assign link_par = par_p0;
`else
  assign link_par = 1'b0;
`endif

endmodule
